// File: rtl/m6502_step_ctrl_if.sv
// Pin bundle between a 6502 board and the step controller: CPU timing inputs,
// raw push-buttons and mode switch in, RDY, halt status and cycle count out.
interface m6502_step_ctrl_if;
    logic        phi2;
    logic        sync;
    logic        btn_step_n;
    logic        btn_run_n;
    logic        mode_cycle;
    logic        rdy;
    logic        halted;
    logic [15:0] cyc_count;

    modport master (
        output phi2, sync, btn_step_n, btn_run_n, mode_cycle,
        input  rdy, halted, cyc_count
    );

    modport slave (
        input  phi2, sync, btn_step_n, btn_run_n, mode_cycle,
        output rdy, halted, cyc_count
    );
endinterface

// File: rtl/m6502_step_ctrl.sv
// Single-step / run controller for a 6502: holds the CPU through RDY and releases it
// for one bus cycle, one instruction, or free running, under push-button control.
module m6502_step_ctrl #(
    parameter int unsigned DB_COUNT = 20000,
    parameter int unsigned DB_WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    m6502_step_ctrl_if.slave bus
);
    localparam int unsigned NBTN     = 2;
    localparam int unsigned BTN_STEP = 0;
    localparam int unsigned BTN_RUN  = 1;
    localparam int unsigned CNT_W    = 16;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    localparam logic [2:0] ST_HALT = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_CYC  = 3'd2;
    localparam logic [2:0] ST_SKIP = 3'd3;
    localparam logic [2:0] ST_SEEK = 3'd4;
    localparam logic [2:0] ST_RUN  = 3'd5;

    // CPU timing synchronizers; phi2_prev_q gives the falling-edge detector
    logic phi2_meta_q, phi2_s_q, phi2_prev_q;
    logic sync_meta_q, sync_s_q;
    logic phi2_fall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_meta_q <= 1'b0;
            phi2_s_q    <= 1'b0;
            phi2_prev_q <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_s_q    <= 1'b0;
        end else begin
            phi2_meta_q <= bus.phi2;
            phi2_s_q    <= phi2_meta_q;
            phi2_prev_q <= phi2_s_q;
            sync_meta_q <= bus.sync;
            sync_s_q    <= sync_meta_q;
        end
    end

    assign phi2_fall_c = phi2_prev_q & ~phi2_s_q;

    // Button synchronizers idle high (released)
    logic [NBTN-1:0] btn_raw_c;
    logic [NBTN-1:0] btn_meta_q, btn_s_q;
    logic [NBTN-1:0] press_w;

    assign btn_raw_c = {bus.btn_run_n, bus.btn_step_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= '1;
            btn_s_q    <= '1;
        end else begin
            btn_meta_q <= btn_raw_c;
            btn_s_q    <= btn_meta_q;
        end
    end

    // A level is accepted only after DB_COUNT consecutive clks differing from the
    // accepted level; the press pulse needs an accepted release in between.
    for (genvar b = 0; b < NBTN; b++) begin : g_db
        logic [DB_WIDTH-1:0] cnt_q, cnt_d;
        logic                lvl_q, lvl_d;
        logic                press_q, press_d;

        always_comb begin
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            press_d = 1'b0;
            if (btn_s_q[b] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_d   = '0;
                lvl_d   = btn_s_q[b];
                press_d = ~btn_s_q[b];
            end else begin
                cnt_d = cnt_q + DB_WIDTH'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                lvl_q   <= 1'b1;
                press_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
            end
        end

        assign press_w[b] = press_q;
    end

    logic step_press_c, run_press_c;
    assign step_press_c = press_w[BTN_STEP];
    assign run_press_c  = press_w[BTN_RUN];

    logic [2:0]       state_q, state_d;
    logic [2:0]       target_q, target_d;
    logic             rdy_q, rdy_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HALT;
            target_q <= ST_HALT;
            rdy_q    <= 1'b0;
            halted_q <= 1'b1;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rdy_q    <= rdy_d;
            halted_q <= halted_d;
            cyc_q    <= cyc_d;
        end
    end

    // Next state; presses not consumed by the current state are dropped
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rdy_d    = 1'b0;
        halted_d = 1'b0;
        cyc_d    = cyc_q;

        unique case (state_q)
            ST_HALT: begin
                if (run_press_c) begin
                    state_d  = ST_ARM;
                    target_d = ST_RUN;
                end else if (step_press_c) begin
                    state_d  = ST_ARM;
                    target_d = bus.mode_cycle ? ST_CYC : ST_SKIP;
                end
            end
            ST_ARM:  if (phi2_fall_c) state_d = target_q;
            ST_CYC:  if (phi2_fall_c) state_d = ST_HALT;
            ST_SKIP: if (phi2_fall_c) state_d = ST_SEEK;
            ST_SEEK: if (phi2_s_q && sync_s_q) state_d = ST_HALT;
            ST_RUN:  if (run_press_c) state_d = ST_SEEK;
            default: state_d = ST_HALT;
        endcase

        rdy_d    = (state_d != ST_HALT) && (state_d != ST_ARM);
        halted_d = (state_d == ST_HALT);

        if (phi2_fall_c && rdy_q) cyc_d = cyc_q + CNT_W'(1);
    end

    assign bus.rdy       = rdy_q;
    assign bus.halted    = halted_q;
    assign bus.cyc_count = cyc_q;
endmodule

// File: tb/tb_m6502_step_ctrl.sv
// Bench for m6502_step_ctrl: directed scenarios followed by random phi2/sync/button
// traffic, checked against a phi2-cycle-level behavioural model.
module tb_m6502_step_ctrl;
    localparam int unsigned DBC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    m6502_step_ctrl_if bus ();

    m6502_step_ctrl #(.DB_COUNT(DBC), .DB_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {M_HALT, M_ARM, M_CYC, M_SKIP, M_SEEK, M_RUN} mstate_t;
    mstate_t     m_st, m_tgt;
    int unsigned m_cnt;
    bit          phi2_lvl, sync_lvl;
    int unsigned cidx;
    int          sync_pat;
    int          checks, errors;

    function automatic bit m_rdy();
        return !(m_st == M_HALT || m_st == M_ARM);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdy"},    32'(bus.rdy),       32'(m_rdy()));
        chk({tag, ".halted"}, 32'(bus.halted),    32'(m_st == M_HALT));
        chk({tag, ".count"},  32'(bus.cyc_count), m_cnt);
    endtask

    // Model: the CPU is held on a fetch once phi2 is high with SYNC in SEEK
    task automatic m_settle();
        if (m_st == M_SEEK && phi2_lvl && sync_lvl) m_st = M_HALT;
    endtask

    task automatic m_fall();
        if (m_rdy()) m_cnt = (m_cnt + 1) % 65536;
        case (m_st)
            M_ARM:   m_st = m_tgt;
            M_CYC:   m_st = M_HALT;
            M_SKIP:  m_st = M_SEEK;
            default: ;
        endcase
    endtask

    task automatic m_press(input bit step, input bit run, input bit mc);
        if (m_st == M_HALT) begin
            if (run) begin
                m_st = M_ARM; m_tgt = M_RUN;
            end else if (step) begin
                m_st = M_ARM; m_tgt = mc ? M_CYC : M_SKIP;
            end
        end else if (m_st == M_RUN && run) begin
            m_st = M_SEEK;
        end
        m_settle();
    endtask

    function automatic bit next_sync();
        if (sync_pat == 1) return (cidx % 3) == 0;
        return $urandom_range(0, 2) == 0;
    endfunction

    task automatic toggle_phi2();
        phi2_lvl = !phi2_lvl;
        bus.phi2 = phi2_lvl;
        if (!phi2_lvl) begin
            m_fall();
            cidx++;
            sync_lvl = next_sync();
            bus.sync = sync_lvl;
        end else begin
            m_settle();
        end
    endtask

    task automatic half();
        toggle_phi2();
        repeat (8) @(negedge clk);
        check_all("half");
    endtask

    task automatic press(input bit step, input bit run, input bit mc, input string tag);
        bus.mode_cycle = mc;
        if (step) bus.btn_step_n = 1'b0;
        if (run)  bus.btn_run_n  = 1'b0;
        repeat (12) @(negedge clk);
        m_press(step, run, mc);
        check_all({tag, ".held"});
        bus.btn_step_n = 1'b1;
        bus.btn_run_n  = 1'b1;
        repeat (12) @(negedge clk);
        check_all({tag, ".rel"});
    endtask

    // 3-clk glitches while phi2 runs, then phi2 stops and the button settles low
    task automatic bounce(input bit use_run, input bit mc);
        bus.mode_cycle = mc;
        for (int k = 0; k < 40; k++) begin
            if (k % 8 == 0) begin
                if (k != 0) check_all("bounce.run");
                toggle_phi2();
            end
            if (use_run) bus.btn_run_n  = ((k / 3) % 2) != 0;
            else         bus.btn_step_n = ((k / 3) % 2) != 0;
            @(negedge clk);
        end
        check_all("bounce.end");
        press(!use_run, use_run, mc, "bounce");
    endtask

    // Run held through a short release glitch and several phi2 cycles
    task automatic hold_run();
        bus.btn_run_n = 1'b0;
        repeat (12) @(negedge clk);
        m_press(1'b0, 1'b1, bus.mode_cycle);
        check_all("hold.acc");
        bus.btn_run_n = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_run_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) half();
        bus.btn_run_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("hold.rel");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.rdy",    32'(bus.rdy),       32'd0);
        chk("rst.halted", 32'(bus.halted),    32'd1);
        chk("rst.count",  32'(bus.cyc_count), 32'd0);
        m_st = M_HALT; m_tgt = M_HALT; m_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_all("rst.rel");
    endtask

    initial begin
        int base;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        phi2_lvl = 1'b0; sync_lvl = 1'b0; cidx = 0; sync_pat = 0;
        bus.phi2 = 1'b0; bus.sync = 1'b0;
        bus.btn_step_n = 1'b1; bus.btn_run_n = 1'b1; bus.mode_cycle = 1'b0;
        m_st = M_HALT; m_tgt = M_HALT; m_cnt = 0;
        repeat (3) @(negedge clk);
        chk("por.rdy",    32'(bus.rdy),       32'd0);
        chk("por.halted", 32'(bus.halted),    32'd1);
        chk("por.count",  32'(bus.cyc_count), 32'd0);
        rst_n = 1'b1;

        // Idle after reset with phi2 running: CPU stays held
        for (int i = 0; i < 125; i++) half();
        chk("idle.rdy",   32'(bus.rdy),       32'd0);
        chk("idle.count", 32'(bus.cyc_count), 32'd0);

        // Single-cycle step
        press(1'b1, 1'b0, 1'b1, "cyc");
        for (int i = 0; i < 5; i++) half();
        chk("cyc.count",  32'(bus.cyc_count), 32'd1);
        chk("cyc.halted", 32'(bus.halted),    32'd1);

        // Single-instruction step with SYNC every third cycle, press one cycle before a fetch
        sync_pat = 1;
        for (int i = 0; i < 12 && !((cidx % 3) == 2 && !phi2_lvl); i++) half();
        base = 32'(bus.cyc_count);
        press(1'b1, 1'b0, 1'b0, "ins");
        for (int i = 0; i < 12; i++) half();
        chk("ins.count",  32'(bus.cyc_count), 32'(base + 3));
        chk("ins.halted", 32'(bus.halted),    32'd1);
        sync_pat = 0;

        bounce(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) half();

        // Simultaneous presses in HALT: run wins, then stop into SEEK with phi2 low
        press(1'b1, 1'b1, 1'b1, "both");
        for (int i = 0; i < 7; i++) half();
        if (phi2_lvl) half();
        press(1'b0, 1'b1, 1'b0, "stop");
        do_reset();

        hold_run();
        for (int i = 0; i < 6; i++) half();

        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 10));
            if ($urandom_range(0, 7) == 0) sync_pat = int'($urandom_range(0, 1));
            case (op)
                0, 1, 2, 3: begin
                    int cnt;
                    cnt = int'($urandom_range(1, 6));
                    for (int i = 0; i < cnt; i++) half();
                end
                4: press(1'b1, 1'b0, 1'($urandom_range(0, 1)), "r.step");
                5: press(1'b0, 1'b1, 1'b0, "r.run");
                6: press(1'b1, 1'b1, 1'($urandom_range(0, 1)), "r.both");
                7: bounce(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                8: hold_run();
                9: begin
                    repeat (200) @(negedge clk);
                    check_all("r.stopped");
                end
                default: if ($urandom_range(0, 3) == 0) do_reset(); else half();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
